// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and index/word types used by the
// register file, the RegDst selector and the ALU.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_file_rport.sv
// One combinational read port: index-to-data mux with the r0-reads-zero rule.
// Same-cycle write forwarding is compiled in only under REG_FILE_BYPASS_EN.
module reg_file_rport
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_idx_i,
  input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
  input  logic              byp_en_i,
  input  logic [ADDR_W-1:0] wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  always_comb begin
    rd_data_o = '0;
    if (rd_idx_i != '0) begin
      rd_data_o = regs_i[rd_idx_i];
`ifdef REG_FILE_BYPASS_EN
      // byp_en_i already excludes reset and writes to r0
      if (byp_en_i && (wr_idx_i == rd_idx_i)) begin
        rd_data_o = wr_data_i;
      end
`endif
    end
  end

`ifndef REG_FILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{byp_en_i, wr_idx_i, wr_data_i};
`endif

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit CPU register file: two operand read ports, one debug read port,
// one synchronous write port and a committed-write counter.
// Optional same-cycle write forwarding: define REG_FILE_BYPASS_EN.
module reg_file
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              RegWre,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] DbgReg,
  output logic [DATA_W-1:0] DbgData,
  output logic [15:0]       WriteCount
);

  localparam int unsigned NumRegs = 2**ADDR_W;

  // r0 has no storage; index 0 of these arrays is never used
  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];
  logic [DATA_W-1:0] regs_all [NumRegs];
  logic [15:0]       cnt_q, cnt_d;
  logic              wr_commit;

  assign wr_commit = RegWre && (WriteReg != '0);

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (wr_commit) begin
      for (int i = 1; i < NumRegs; i++) begin
        if (WriteReg == ADDR_W'(i)) begin
          regs_d[i] = WriteData;
        end
      end
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 1; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 1; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    regs_all[0] = '0;
    for (int i = 1; i < NumRegs; i++) begin
      regs_all[i] = regs_q[i];
    end
  end

  logic unused_r0;
  assign unused_r0 = ^{regs_q[0], regs_d[0]};

  logic byp_en;
  assign byp_en = wr_commit && !Reset;

  reg_file_rport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rport1 (
    .rd_idx_i  (ReadReg1),
    .regs_i    (regs_all),
    .byp_en_i  (byp_en),
    .wr_idx_i  (WriteReg),
    .wr_data_i (WriteData),
    .rd_data_o (ReadData1)
  );

  reg_file_rport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rport2 (
    .rd_idx_i  (ReadReg2),
    .regs_i    (regs_all),
    .byp_en_i  (byp_en),
    .wr_idx_i  (WriteReg),
    .wr_data_i (WriteData),
    .rd_data_o (ReadData2)
  );

  reg_file_rport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rport_dbg (
    .rd_idx_i  (DbgReg),
    .regs_i    (regs_all),
    .byp_en_i  (byp_en),
    .wr_idx_i  (WriteReg),
    .wr_data_i (WriteData),
    .rd_data_o (DbgData)
  );

  assign WriteCount = cnt_q;

endmodule
